// File: rtl/button_mem_writer.sv
// button_mem_writer
//   Synchronizes and debounces the active-low left/right/start keys, and
//   publishes each debounced level change as a one-word memory write. The
//   write goes through a request/grant port so the CPU can poll the keys with
//   plain loads.
//
// Ports
//   clk                      system clock
//   reset                    asynchronous, active-high reset
//   left, right, start       raw keys, active-low, asynchronous to clk
//   mem_grant                arbiter grant, only looked at while in REQ
//   mem_req                  write request (high in REQ and WRITE)
//   mem_we                   write strobe, one cycle per write
//   mem_addr                 registered target address
//   mem_data                 registered write data (bit 0 = pressed)
//   left_lvl, right_lvl,
//   start_lvl                debounced levels, active-high
module button_mem_writer #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_BITS        = 18,
    parameter int LEFTP           = 6024,
    parameter int RIGHTP          = 6028,
    parameter int STARTP          = 6032
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             start,
    input  logic             mem_grant,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_data,
    output logic             left_lvl,
    output logic             right_lvl,
    output logic             start_lvl
);

    // Key index order used by every per-key vector below.
    localparam int unsigned K_LEFT  = 0;
    localparam int unsigned K_RIGHT = 1;
    localparam int unsigned K_START = 2;

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer, idles at 1 (released)
    // ------------------------------------------------------------------
    logic [2:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {start, right, left};
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers: a level change is accepted only after the synced value
    // has disagreed with the current level for DEBOUNCE_CYCLES edges in a
    // row; any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    logic [2:0]          pressed;
    logic [2:0]          lvl_q, lvl_d;
    logic [CNT_BITS-1:0] cnt_q [3];
    logic [CNT_BITS-1:0] cnt_d [3];

    assign pressed = ~sync2_q;

    always_comb begin
        lvl_d = lvl_q;
        for (int unsigned k = 0; k < 3; k++) begin
            cnt_d[k] = cnt_q[k];
            if (pressed[k] == lvl_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_MAX) begin
                cnt_d[k] = '0;
                lvl_d[k] = ~lvl_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_q <= '0;
            for (int unsigned k = 0; k < 3; k++) cnt_q[k] <= '0;
        end else begin
            lvl_q <= lvl_d;
            for (int unsigned k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign left_lvl  = lvl_q[K_LEFT];
    assign right_lvl = lvl_q[K_RIGHT];
    assign start_lvl = lvl_q[K_START];

    // ------------------------------------------------------------------
    // Pending flags: set the cycle after a level toggles (edge detect
    // against the previous level), cleared when that key's write leaves
    // WRITE. A toggle on the clearing edge keeps the flag set.
    // ------------------------------------------------------------------
    state_t     state_q;
    logic [2:0] sel_q;
    logic [2:0] lvl_prev_q;
    logic [2:0] pend_q, pend_d;
    logic [2:0] toggled, clr;

    assign toggled = lvl_q ^ lvl_prev_q;
    assign clr     = (state_q == WRITE) ? sel_q : '0;

    always_comb begin
        pend_d = (pend_q & ~clr) | toggled;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_prev_q <= '0;
            pend_q     <= '0;
        end else begin
            lvl_prev_q <= lvl_q;
            pend_q     <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Writer FSM with registered outputs. Address/data are latched from
    // the current level on leaving IDLE, so later changes produce a
    // follow-up write instead of altering this one.
    // ------------------------------------------------------------------
    logic             req_q, we_q;
    logic [WIDTH-1:0] addr_q, data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_q <= 1'b0;
                    we_q  <= 1'b0;
                    if (|pend_q) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        if (pend_q[K_START]) begin
                            addr_q <= WIDTH'(STARTP);
                            data_q <= {{(WIDTH-1){1'b0}}, lvl_q[K_START]};
                            sel_q  <= 3'b100;
                        end else if (pend_q[K_LEFT]) begin
                            addr_q <= WIDTH'(LEFTP);
                            data_q <= {{(WIDTH-1){1'b0}}, lvl_q[K_LEFT]};
                            sel_q  <= 3'b001;
                        end else begin
                            addr_q <= WIDTH'(RIGHTP);
                            data_q <= {{(WIDTH-1){1'b0}}, lvl_q[K_RIGHT]};
                            sel_q  <= 3'b010;
                        end
                    end
                end
                REQ: begin
                    req_q <= 1'b1;
                    if (mem_grant) begin
                        state_q <= WRITE;
                        we_q    <= 1'b1;
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = req_q;
    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;

endmodule

// File: tb/tb_button_mem_writer.sv
module tb_button_mem_writer;

    logic        clk = 1'b0;
    logic        reset, left, right, start, mem_grant;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_data;
    logic        left_lvl, right_lvl, start_lvl;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] wa[$];
    logic [15:0] wd[$];
    int          wt[$];

    button_mem_writer #(
        .WIDTH(16),
        .DEBOUNCE_CYCLES(4),
        .CNT_BITS(3),
        .LEFTP(6024),
        .RIGHTP(6028),
        .STARTP(6032)
    ) dut (
        .clk(clk),
        .reset(reset),
        .left(left),
        .right(right),
        .start(start),
        .mem_grant(mem_grant),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .left_lvl(left_lvl),
        .right_lvl(right_lvl),
        .start_lvl(start_lvl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            wt.push_back(cyc);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wt.delete();
    endtask

    initial begin
        reset = 1'b1; left = 1'b1; right = 1'b1; start = 1'b1; mem_grant = 1'b0;
        #3;
        // Reset state
        chk("rst_req",  64'(mem_req), 64'd0);
        chk("rst_we",   64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_data", 64'(mem_data), 64'd0);
        chk("rst_lvls", 64'({left_lvl, right_lvl, start_lvl}), 64'd0);
        step(2);
        reset = 1'b0;
        clear_log();
        step(20);
        chk("idle_no_write", 64'(wa.size()), 64'd0);

        // Clean press of left, grant tied high
        mem_grant = 1'b1;
        left = 1'b0;
        step(5);
        chk("press_lvl_c5", 64'(left_lvl), 64'd0);
        step(1);
        chk("press_lvl_c6", 64'(left_lvl), 64'd1);
        chk("press_req_c6", 64'(mem_req), 64'd0);
        step(1);
        chk("press_req_c7", 64'(mem_req), 64'd0);
        step(1);
        chk("press_req_c8", 64'({mem_req, mem_we}), 64'b10);
        chk("press_addr_c8", 64'(mem_addr), 64'd6024);
        chk("press_data_c8", 64'(mem_data), 64'h0001);
        step(1);
        chk("press_we_c9", 64'({mem_req, mem_we}), 64'b11);
        chk("press_addr_c9", 64'(mem_addr), 64'd6024);
        step(1);
        chk("press_idle_c10", 64'({mem_req, mem_we}), 64'b00);

        // Release left
        clear_log();
        left = 1'b1;
        step(12);
        chk("rel_lvl", 64'(left_lvl), 64'd0);
        chk("rel_count", 64'(wa.size()), 64'd1);
        if (wa.size() >= 1) begin
            chk("rel_addr", 64'(wa[0]), 64'd6024);
            chk("rel_data", 64'(wd[0]), 64'h0000);
        end

        // Bouncing right key
        clear_log();
        for (int i = 0; i < 20; i++) begin
            right = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        chk("bounce_no_write", 64'(wa.size()), 64'd0);
        chk("bounce_lvl", 64'(right_lvl), 64'd0);
        right = 1'b0;
        step(15);
        chk("bounce_lvl_settled", 64'(right_lvl), 64'd1);
        chk("bounce_count", 64'(wa.size()), 64'd1);
        if (wa.size() >= 1) begin
            chk("bounce_addr", 64'(wa[0]), 64'd6028);
            chk("bounce_data", 64'(wd[0]), 64'h0001);
        end
        right = 1'b1;
        step(12);

        // Simultaneous start and left
        clear_log();
        start = 1'b0;
        left  = 1'b0;
        step(15);
        chk("simul_count", 64'(wa.size()), 64'd2);
        if (wa.size() >= 2) begin
            chk("simul_addr0", 64'(wa[0]), 64'd6032);
            chk("simul_data0", 64'(wd[0]), 64'h0001);
            chk("simul_addr1", 64'(wa[1]), 64'd6024);
            chk("simul_data1", 64'(wd[1]), 64'h0001);
            chk("simul_spacing", 64'(wt[1] - wt[0]), 64'd3);
        end

        // Grant stall on start release, with a right press/release merged
        mem_grant = 1'b0;
        clear_log();
        start = 1'b1;
        step(8);
        chk("stall_req_rise", 64'({mem_req, mem_we}), 64'b10);
        for (int i = 0; i < 50; i++) begin
            if (i == 0)  right = 1'b0;
            if (i == 10) right = 1'b1;
            step(1);
            chk("stall_hold", 64'({mem_req, mem_we, mem_addr, mem_data}),
                64'({1'b1, 1'b0, 16'd6032, 16'h0000}));
        end
        chk("stall_no_write", 64'(wa.size()), 64'd0);
        mem_grant = 1'b1;
        step(1);
        chk("stall_we_pulse", 64'({mem_req, mem_we}), 64'b11);
        step(1);
        chk("stall_we_end", 64'(mem_we), 64'd0);
        step(8);
        chk("merge_count", 64'(wa.size()), 64'd2);
        if (wa.size() >= 2) begin
            chk("merge_addr0", 64'(wa[0]), 64'd6032);
            chk("merge_data0", 64'(wd[0]), 64'h0000);
            chk("merge_addr1", 64'(wa[1]), 64'd6028);
            chk("merge_data1", 64'(wd[1]), 64'h0000);
        end

        // Reset mid-REQ (left still held, right pressed to start a request)
        mem_grant = 1'b0;
        right = 1'b0;
        step(8);
        chk("mid_req_up", 64'({mem_req, left_lvl, right_lvl}), 64'b111);
        reset = 1'b1;
        left = 1'b1; right = 1'b1; start = 1'b1;
        #1;
        chk("mid_rst_req_we", 64'({mem_req, mem_we}), 64'b00);
        chk("mid_rst_lvls", 64'({left_lvl, right_lvl, start_lvl}), 64'd0);
        step(2);
        reset = 1'b0;
        mem_grant = 1'b1;
        clear_log();
        step(20);
        chk("post_rst_no_write", 64'(wa.size()), 64'd0);
        chk("post_rst_req", 64'(mem_req), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/button_mem_writer.md
# button_mem_writer

Memory-side producer for the player inputs. It synchronizes and debounces the raw `left`, `right` and `start` pushbuttons, and detects changes in each debounced level. Each change is written into a memory-mapped word through a request/grant write port, so the CPU can poll the buttons as ordinary loads. It sits between the board keys and the write-arbitration mux in front of `basic_mem`, and is the writing counterpart to the sprite-position reader that feeds the VGA block.

## Interface
- `WIDTH`, 16, memory data and address width.
- `DEBOUNCE_CYCLES`, 250000, consecutive stable cycles required before a level change is accepted (5 ms at 50 MHz); minimum 2.
- `CNT_BITS`, 18, width of each debounce counter; must hold `DEBOUNCE_CYCLES-1`.
- `LEFTP`, 6024, word address for the left button.
- `RIGHTP`, 6028, word address for the right button.
- `STARTP`, 6032, word address for the start button.

- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `left`, `right`, `start`  in  1 each  raw keys, active-low (0 = pressed), asynchronous to `clk`.
- `mem_grant`  in  1  arbiter grants the write port; sampled only while `mem_req`=1.
- `mem_req`  out  1  write request.
- `mem_we`  out  1  write strobe; high for exactly one cycle per write.
- `mem_addr`  out  WIDTH  target address.
- `mem_data`  out  WIDTH  write data.
- `left_lvl`, `right_lvl`, `start_lvl`  out  1 each  debounced levels, active-high (1 = pressed).

## Operation
- **Synchronizer:** two flops per key, reset to 1 (released). The synced value is inverted so that 1 = pressed.
- **Debouncer, per key:**
  - Counter clears whenever the synced value equals `*_lvl`.
  - While they differ, the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the values still differ, `*_lvl` toggles and the counter clears.
  - A single mismatching-then-matching sample restarts the count.
- **Pending flags, one per key:**
  - Set on the cycle after `*_lvl` toggles.
  - Cleared when that key's write completes in WRITE.
  - If a new toggle and the clear fall on the same cycle, set wins.
  - Pending never counts; multiple toggles while pending yield one write carrying the latest level.
- **Writer FSM:**
  - IDLE: `mem_req`=0, `mem_we`=0. If any pending flag is set, select by priority start > left > right. Latch `mem_addr` with the key's address and `mem_data` with `{(WIDTH-1)'b0, *_lvl}`. Go to REQ.
  - REQ: `mem_req`=1, address and data held stable. If `mem_grant`=1 at the edge, go to WRITE; otherwise stay in REQ indefinitely.
  - WRITE: `mem_req`=1, `mem_we`=1 for one cycle. Clear the selected pending flag (subject to the set-wins rule). Go to IDLE.
  - Unused encodings go to IDLE.
- **Data word:** 0x0001 = pressed, 0x0000 = released. Upper bits are always 0.
- A level change occurring after the word was latched in IDLE is not merged into the current write. It re-sets pending and produces a follow-up write.

## Timing
- **Reset values:** state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, all `*_lvl`=0, all pending flags 0, all counters 0, synchronizer flops 1.
- **Reset mid-operation:** any state returns to IDLE immediately. A write in progress is abandoned, with `mem_we` low asynchronously.
- **Key to level:** a raw edge stable at cycle 0 gives synced value at cycle 2 and `*_lvl` toggle at cycle 2+`DEBOUNCE_CYCLES`.
- **Level to request:**
  - `*_lvl` toggle at edge t → pending at t+1 → FSM in REQ (`mem_req`=1) at t+2.
  - With `mem_grant` tied high: WRITE (`mem_we`=1) at t+3, IDLE at t+4.
- **Minimum spacing:** two back-to-back writes are 3 cycles apart (IDLE, REQ, WRITE).
- **Latched outputs:** `mem_addr` and `mem_data` are registered. They are unchanged from REQ entry through the end of WRITE and hold their last values in IDLE.
- `mem_grant` is ignored in IDLE and WRITE.

## Test plan
- **Reset:** assert `reset` mid-REQ → `mem_req`, `mem_we` and all `*_lvl` drop to 0 in the same cycle; after release, no write occurs with keys idle (all 1).
- **Clean press:** `DEBOUNCE_CYCLES`=4, grant tied 1, `left` 1→0 at cycle 0 → `left_lvl`=1 at cycle 6; `mem_we`=1 at cycle 9 with addr 6024, data 0x0001. Release → data 0x0000.
- **Bounce:** `right` toggling every 2 cycles for 20 cycles, then held 0 → no write during bouncing; exactly one write (addr 6028, data 0x0001) after it settles.
- **Simultaneous:** `start` and `left` pressed on the same cycle → writes in order 6032 then 6024, 3 cycles apart, both data 0x0001.
- **Grant stall:** grant held 0 for 50 cycles after `mem_req` rises → `mem_req` stays 1 with addr/data stable and `mem_we`=0. Grant 1 → `mem_we` pulses exactly one cycle after.
- **Merge:** press and release `right` while `mem_grant`=0 and the FSM is busy with `start` → after the `start` write, one `right` write with data 0x0000.
